tdc_result_packer: RTL

- Downstream consumer of the TDC core's measurement stream.
- Buffers each 40-bit measurement, accepted on a single-cycle valid pulse, in a small synchronous FIFO.
- Serialises each buffered measurement into a fixed 7-byte framed packet on a byte-wide valid/ready stream for the UART transmitter.
- Counts and flags measurements dropped when the FIFO is full.

---
 rtl/tdc_pkg.sv | 18 +
 rtl/tdc_sync_fifo.sv | 62 ++++++
 rtl/tdc_result_packer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types, constants and checksum helper for the TDC result packer.
// A packet is the sync byte, the five measurement bytes (MSB first), then their XOR.
package tdc_pkg;

  localparam int         MEAS_W        = 40;
  localparam int         PKT_BYTES     = 7;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdc_state_e;

  function automatic logic [7:0] meas_chk(input logic [MEAS_W-1:0] m);
    return m[39:32] ^ m[31:24] ^ m[23:16] ^ m[15:8] ^ m[7:0];
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module tdc_sync_fifo
  import tdc_pkg::*;
#(
  parameter int WIDTH = MEAS_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tdc_result_packer.sv
// Buffers TDC measurements and serialises each into a 7-byte framed packet
// on a byte-wide valid/ready stream; tracks measurements dropped on a full FIFO.
//
//   state | meaning
//   IDLE  | no packet in flight; pops the FIFO head as soon as one is present
//   SEND  | presenting packet byte idx_q on tx_data with tx_valid high
module tdc_result_packer
  import tdc_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MEAS_W-1:0]            meas_in,
  input  logic                         meas_valid_in,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic                         clr_overflow,
  output logic                         overflow,
  output logic [7:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy
);

  tdc_state_e        state_q, state_d;
  logic [MEAS_W-1:0] hold_q, hold_d;
  logic [7:0]        chk_q, chk_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [MEAS_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              pop, push, drop;

  function automatic logic [7:0] pkt_byte(input logic [2:0] idx,
                                          input logic [MEAS_W-1:0] m,
                                          input logic [7:0] c);
    case (idx)
      3'd0:    return SYNC_BYTE;
      3'd1:    return m[39:32];
      3'd2:    return m[31:24];
      3'd3:    return m[23:16];
      3'd4:    return m[15:8];
      3'd5:    return m[7:0];
      3'd6:    return c;
      default: return 8'h00;
    endcase
  endfunction

  assign pop  = (state_q == IDLE) && !fifo_empty;
  assign push = meas_valid_in && (!fifo_full || pop);
  assign drop = meas_valid_in && fifo_full && !pop;

  tdc_sync_fifo #(
    .WIDTH (MEAS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (meas_in),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The next byte is chosen one cycle early so tx_data/tx_valid come straight from flops.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d    = SEND;
          hold_d     = fifo_head;
          chk_d      = meas_chk(fifo_head);
          idx_d      = 3'd0;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
        end
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == 3'(PKT_BYTES - 1)) begin
            state_d    = IDLE;
            idx_d      = 3'd0;
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = pkt_byte(idx_q + 3'd1, hold_q, chk_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the clearing cycle still counts, so it restarts the count at 1.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow)            drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      chk_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign busy       = (state_q == SEND);

endmodule
